// File: rtl/echo_pkg.sv
// Shared definitions for the UART echo block: baud divisors at 12 MHz,
// frame length and the receiver/transmitter state encodings.
package echo_pkg;

  localparam int B115200   = 104;
  localparam int B57600    = 208;
  localparam int B38400    = 313;
  localparam int B19200    = 625;
  localparam int B9600     = 1250;
  localparam int FRAME_LEN = 10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE    = 1'b0,
    TX_SENDING = 1'b1
  } tx_state_t;

endpackage

// File: rtl/echo_uart_rx.sv
// 8N1 UART receiver: double-synchronises rx, samples mid-bit and pulses
// o_rcv for one cycle when a frame with a valid stop bit has been received.
module uart_rx
  import echo_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rcv
);

  localparam int CW = $clog2(BAUD) + 1;

  logic            r_meta;
  logic            r_sync;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      o_data  <= 8'h00;
      o_rcv   <= 1'b0;
    end else begin
      o_rcv <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_sync) begin
            r_cnt   <= CW'(BAUD / 2);
            r_state <= RX_START;
          end
        end
        // A start bit that has gone high again by mid-bit is treated as a glitch.
        RX_START: begin
          if (r_cnt == {CW{1'b0}}) begin
            if (r_sync) begin
              r_state <= RX_IDLE;
            end else begin
              r_cnt   <= CW'(BAUD - 1);
              r_bit   <= 3'd0;
              r_state <= RX_DATA;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_shift <= {r_sync, r_shift[7:1]};
            r_cnt   <= CW'(BAUD - 1);
            if (r_bit == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == {CW{1'b0}}) begin
            if (r_sync) begin
              o_data <= r_shift;
              o_rcv  <= 1'b1;
            end
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/echo_uart_tx.sv
// 8N1 UART transmitter with a registered tx line. o_ready is also high in the
// last cycle of a stop bit so a queued byte follows with no idle gap.
module uart_tx
  import echo_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_ready
);

  localparam int CW = $clog2(BAUD) + 1;

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          w_load;

  assign w_load = i_start & o_ready;

  // r_bit is the index of the bit currently on the wire (0 = start, 9 = stop).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 4'd0;
      r_shift <= 9'h1FF;
      o_tx    <= 1'b1;
      o_ready <= 1'b1;
    end else if (w_load) begin
      r_state <= TX_SENDING;
      r_cnt   <= CW'(BAUD - 1);
      r_bit   <= 4'd0;
      r_shift <= {1'b1, i_data};
      o_tx    <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          o_tx    <= 1'b1;
          o_ready <= 1'b1;
        end
        TX_SENDING: begin
          if (r_cnt == {CW{1'b0}}) begin
            if (r_bit == 4'(FRAME_LEN - 1)) begin
              r_state <= TX_IDLE;
              o_tx    <= 1'b1;
              o_ready <= 1'b1;
            end else begin
              o_tx    <= r_shift[0];
              r_shift <= {1'b1, r_shift[8:1]};
              r_bit   <= r_bit + 4'd1;
              r_cnt   <= CW'(BAUD - 1);
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && r_bit == 4'(FRAME_LEN - 1)) begin
              o_ready <= 1'b1;
            end else begin
              o_ready <= 1'b0;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/echo.sv
// UART loopback: every byte received with a valid stop bit is retransmitted
// unchanged, buffered through a one-byte holding register.
module echo
  import echo_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_tx
);

  logic [7:0] w_rx_data;
  logic       w_rcv;
  logic       w_ready;
  logic       w_start;
  logic [7:0] r_hold;
  logic       r_full;

  assign w_start = r_full & w_ready;

  uart_rx #(.BAUD(BAUD)) u_rx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_data (w_rx_data),
    .o_rcv  (w_rcv)
  );

  uart_tx #(.BAUD(BAUD)) u_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_data  (r_hold),
    .o_tx    (o_tx),
    .o_ready (w_ready)
  );

  // A byte arriving while the register is full and not draining is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= 8'h00;
      r_full <= 1'b0;
    end else if (w_rcv && (!r_full || w_start)) begin
      r_hold <= w_rx_data;
      r_full <= 1'b1;
    end else if (w_start) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

endmodule

// File: tb/tb_echo.sv
// Directed bench for the UART echo block: drives 8N1 frames on rx and decodes
// the echoed frames on tx at mid-bit, checking content, timing and reset.
module tb_echo;

  localparam int BT = 208;

  logic clk;
  logic rst;
  logic rx;
  logic tx;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   rcv_cnt  = 0;
  int   n_before;
  time  t_rcv    = 0;

  logic [9:0] q_frame[$];
  time        q_start[$];
  time        q_edge[$];

  echo #(.BAUD(104)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_rx  (rx),
    .o_tx  (tx)
  );

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  always @(tx) begin
    if (!rst) q_edge.push_back($time);
  end

  always @(posedge dut.w_rcv) begin
    t_rcv = $time;
    rcv_cnt++;
  end

  initial begin : frame_mon
    logic [9:0] v;
    time        t;
    forever begin
      @(negedge tx);
      t = $time;
      #103;
      v[0] = tx;
      for (int i = 1; i < 10; i++) begin
        #208;
        v[i] = tx;
      end
      q_frame.push_back(v);
      q_start.push_back(t);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    #BT;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #BT;
    end
    rx = stop_b;
    #BT;
    rx = 1'b1;
  endtask

  task automatic clear_q();
    q_frame.delete();
    q_start.delete();
    q_edge.delete();
  endtask

  function automatic logic [31:0] fr(input int i);
    return (i < q_frame.size()) ? 32'(q_frame[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] st_gap(input int i);
    return (i + 1 < q_start.size()) ? 32'(q_start[i+1] - q_start[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    #10;
    chk("reset_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    #(2*BT);
    chk("idle_tx", 32'(tx), 32'd1);

    // 1: 0x55 after idle, each bit 104 clk wide, start 2 clk after rcv
    clear_q();
    send(8'h55, 1'b1);
    #(12*BT);
    chk("t1_nframes", 32'(q_frame.size()), 32'd1);
    chk("t1_frame", fr(0), 32'({1'b1, 8'h55, 1'b0}));
    chk("t1_nedges", 32'(q_edge.size()), 32'd10);
    for (int i = 1; i < 10; i++) begin
      chk("t1_bitwidth", (i < q_edge.size()) ? 32'(q_edge[i] - q_edge[i-1]) : 32'hFFFF_FFFF, 32'd208);
    end
    chk("t1_latency", (q_start.size() > 0) ? 32'(q_start[0] - t_rcv) : 32'hFFFF_FFFF, 32'd4);

    // 2: 'K' after a 12-bit-time gap
    clear_q();
    send(8'h4B, 1'b1);
    #(12*BT);
    chk("t2_nframes", 32'(q_frame.size()), 32'd1);
    chk("t2_frame", fr(0), 32'({1'b1, 8'h4B, 1'b0}));

    // 3: short low glitch on rx
    n_before = rcv_cnt;
    clear_q();
    rx = 1'b0;
    #40;
    rx = 1'b1;
    #(12*BT);
    chk("t3_rcv", 32'(rcv_cnt), 32'(n_before));
    chk("t3_nframes", 32'(q_frame.size()), 32'd0);
    chk("t3_tx", 32'(tx), 32'd1);

    // 4: framing error discarded, then a valid byte
    n_before = rcv_cnt;
    clear_q();
    send(8'hA3, 1'b0);
    #(2*BT);
    chk("t4_bad_rcv", 32'(rcv_cnt), 32'(n_before));
    chk("t4_bad_nframes", 32'(q_frame.size()), 32'd0);
    chk("t4_bad_tx", 32'(tx), 32'd1);
    send(8'h3C, 1'b1);
    #(12*BT);
    chk("t4_rcv", 32'(rcv_cnt), 32'(n_before + 1));
    chk("t4_nframes", 32'(q_frame.size()), 32'd1);
    chk("t4_frame", fr(0), 32'({1'b1, 8'h3C, 1'b0}));

    // 5: three back-to-back frames, echoed with no gap
    clear_q();
    send(8'h01, 1'b1);
    send(8'h80, 1'b1);
    send(8'hFF, 1'b1);
    #(12*BT);
    chk("t5_nframes", 32'(q_frame.size()), 32'd3);
    chk("t5_frame0", fr(0), 32'({1'b1, 8'h01, 1'b0}));
    chk("t5_frame1", fr(1), 32'({1'b1, 8'h80, 1'b0}));
    chk("t5_frame2", fr(2), 32'({1'b1, 8'hFF, 1'b0}));
    chk("t5_gap01", st_gap(0), 32'd2080);
    chk("t5_gap12", st_gap(1), 32'd2080);

    // 6: reset during the data bits of an echo
    clear_q();
    send(8'h55, 1'b1);
    #(2*BT);
    chk("t6_midframe", 32'(q_edge.size() > 0), 32'd1);
    rst = 1'b1;
    #2;
    chk("t6_tx_reset", 32'(tx), 32'd1);
    #20;
    rst = 1'b0;
    q_edge.delete();
    #(12*BT);
    chk("t6_no_partial", 32'(q_edge.size()), 32'd0);
    chk("t6_idle_tx", 32'(tx), 32'd1);
    clear_q();
    send(8'h55, 1'b1);
    #(12*BT);
    chk("t6_nframes", 32'(q_frame.size()), 32'd1);
    chk("t6_frame", fr(0), 32'({1'b1, 8'h55, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
